spi_target_regfile: RTL and testbench
=====================================

Name: spi_target_regfile

Overview:
- SPI responder (target) end of the team's SPI link: decodes controller frames into reads and writes of a small local register bank.
- Runs on the local system clock and oversamples SCK, CS and COPI through synchronizers. It does not clock logic on SCK.
- Sits behind one CS_out line of the SPI controller. CIPO is a shared tri-state line with the other peripherals.

Parameters:
- ADDR_WIDTH, 3: register address bits; the bank holds 2**ADDR_WIDTH registers.
- DATA_WIDTH, 8: register width. Each SPI byte/word is DATA_WIDTH bits.
- ID_VALUE, 8'hA5: read-only contents of register 0 (width DATA_WIDTH).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- SCK  in  1  serial clock from controller; mode 0 (CPOL=0, CPHA=0)
- CS  in  1  chip select, active-high (one-hot line from controller)
- COPI  in  1  controller-out peripheral-in serial data
- CIPO  out(tri)  1  peripheral-out serial data; high-Z when not selected
- loc_addr  in  ADDR_WIDTH  local combinational read address
- loc_data  out  DATA_WIDTH  contents of register loc_addr (combinational)
- wr_pulse  out  1  one-clk strobe when a register is written
- wr_addr  out  ADDR_WIDTH  address of the write; valid with wr_pulse
- wr_data  out  DATA_WIDTH  data written; valid with wr_pulse
- frame_err  out  1  one-clk strobe when a frame aborts mid-word

Behaviour:
- Sync and edge detect
  - SCK, CS and COPI each pass through a 2-flop synchronizer.
  - SCK rise/fall are detected on the synchronized value.
  - SCK high and low phases must each be at least 2 clk.
- Reset (rst=0 at a clk edge)
  - Registers 1..N-1 = 0; register 0 = ID_VALUE always.
  - wr_pulse = 0, frame_err = 0, state = IDLE, bit counter = 0, shift registers = 0, CIPO = high-Z.
  - A frame in progress when reset asserts is discarded. The block restarts only on the next synchronized CS rising edge.
- State machine: IDLE -> CMD -> DATA (repeating) -> IDLE.
  - IDLE: waits for the CS rising edge, then clears the bit counter and enters CMD. CIPO drives 0 while CS is high.
  - CMD: shifts COPI into cmd_sr MSB-first on each SCK rise. Command format, DATA_WIDTH bits:
    - bit[DATA_WIDTH-1] = write (1) / read (0)
    - bits[ADDR_WIDTH-1:0] = start address
    - remaining bits are ignored.
  - End of CMD: on the DATA_WIDTH-th SCK rise, latch the direction and pointer, then enter DATA.
    - Read: in that same cycle, load tx_sr with reg[pointer] and drive its MSB on CIPO, so it is valid before the next SCK rise.
  - DATA, write: shift COPI into rx_sr on each SCK rise. On the DATA_WIDTH-th rise of each word:
    - write reg[pointer] on the next clk, with wr_pulse=1 for exactly that clk;
    - wr_addr/wr_data reflect the write;
    - increment the pointer.
    - Writes to address 0 are dropped: no register change, no wr_pulse. The pointer still increments.
  - DATA, read: on each SCK fall, shift tx_sr left and drive the new MSB on CIPO. On the DATA_WIDTH-th rise of each word:
    - increment the pointer;
    - reload tx_sr with reg[new pointer] for the next word.
  - Burst: words continue until CS falls. The pointer wraps modulo 2**ADDR_WIDTH (e.g. 7 -> 0).
  - CS fall in any state: return to IDLE; CIPO goes high-Z.
    - If the bit count within the current word is nonzero, pulse frame_err for one clk and discard the partial word (no write).
    - If CS falls during CMD with fewer than DATA_WIDTH bits, frame_err=1 as well.
- Write/read collision
  - A local loc_addr read in the same clk as an SPI write returns the old value; the new value is visible the next clk.
  - A read burst that rereads a just-written address returns the new value.
- SCK edges while CS is low are ignored.

Test Plan:
- Reset then ID read: CS=1, send cmd 8'h00, clock 8 more bits -> CIPO returns 8'hA5 MSB-first; loc_data with loc_addr=0 = 8'hA5; no wr_pulse.
- Single write: cmd 8'h83, data 8'h3C -> one wr_pulse with wr_addr=3, wr_data=8'h3C; loc_addr=3 -> loc_data=8'h3C. Then read cmd 8'h03 -> CIPO returns 8'h3C.
- Wrapping burst write: cmd 8'h86, data 8'h11,8'h22,8'h33 -> reg6=8'h11, reg7=8'h22; addr 0 dropped; exactly 2 wr_pulses; pointer wrap is checked by a following read burst from 6 returning 11,22,A5.
- Abort: cmd 8'h85, 4 data bits, CS falls -> frame_err pulses once, reg5 unchanged, no wr_pulse; next full frame works normally.
- Reset mid-frame: rst=0 during a write data word, then released with CS still high -> no write, and SCK activity is ignored until CS falls and rises again. Regs are 0 except reg0=8'hA5.
- Deselected: CS=0 with SCK toggling and COPI data -> CIPO stays high-Z; no register, wr_pulse or frame_err activity.

Source files
------------

// File: rtl/spi_target_regfile_if.sv
// Bus bundle for spi_target_regfile: the synchronous-side SPI inputs from the
// controller plus the local register-bank observation/notification signals.
// CIPO is a shared tri-state line and stays a plain port on the target.
interface spi_target_regfile_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  SCK;
    logic                  CS;
    logic                  COPI;
    logic [ADDR_WIDTH-1:0] loc_addr;
    logic [DATA_WIDTH-1:0] loc_data;
    logic                  wr_pulse;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  frame_err;

    modport slave (
        input  SCK, CS, COPI, loc_addr,
        output loc_data, wr_pulse, wr_addr, wr_data, frame_err
    );

    modport master (
        output SCK, CS, COPI, loc_addr,
        input  loc_data, wr_pulse, wr_addr, wr_data, frame_err
    );
endinterface

// File: rtl/spi_target_regfile.sv
// SPI mode-0 target that maps controller frames onto a small register bank.
// SCK/CS/COPI are oversampled on clk; nothing is clocked on SCK. Frame layout:
// one command word (MSB = write flag, low bits = start address) followed by a
// burst of data words with an auto-incrementing, wrapping pointer.
module spi_target_regfile #(
    parameter int                    ADDR_WIDTH = 3,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_target_regfile_if.slave  bus,
    output tri                   CIPO
);
    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    // Synchronizer stages; the third SCK/CS stage is only for edge detection.
    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic copi_s1_q, copi_s2_q;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-2:0] cmd_sr_q, cmd_sr_d;
    logic [DATA_WIDTH-2:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic                  dir_wr_q, dir_wr_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_err_q, frame_err_d;
    logic                  cipo_oe_q;

    // Register 0 is the constant ID and has no storage.
    logic [DATA_WIDTH-1:0] regs_q [1:NREGS-1];

    logic sck_rise, sck_fall, cs_rise, cs_fall, cipo_bit;
    logic [DATA_WIDTH-1:0] cmd_word, rx_word;

    function automatic logic [DATA_WIDTH-1:0] rd_reg(input logic [ADDR_WIDTH-1:0] a);
        rd_reg = ID_VALUE;
        for (int i = 1; i < NREGS; i++) begin
            if (a == ADDR_WIDTH'(i)) rd_reg = regs_q[i];
        end
    endfunction

    // Two-flop synchronizers plus edge-detect history; free-running, no reset needed.
    always_ff @(posedge clk) begin
        sck_s1_q  <= bus.SCK;
        sck_s2_q  <= sck_s1_q;
        sck_s3_q  <= sck_s2_q;
        cs_s1_q   <= bus.CS;
        cs_s2_q   <= cs_s1_q;
        cs_s3_q   <= cs_s2_q;
        copi_s1_q <= bus.COPI;
        copi_s2_q <= copi_s1_q;
    end

    assign sck_rise = sck_s2_q & ~sck_s3_q;
    assign sck_fall = ~sck_s2_q & sck_s3_q;
    assign cs_rise  = cs_s2_q & ~cs_s3_q;
    assign cs_fall  = ~cs_s2_q & cs_s3_q;

    // Word as it stands once the bit arriving on this SCK rise is included.
    assign cmd_word = {cmd_sr_q, copi_s2_q};
    assign rx_word  = {rx_sr_q, copi_s2_q};

    // Frame FSM: next state, shift registers, pointer and strobes.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        dir_wr_d    = dir_wr_q;
        ptr_d       = ptr_q;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        if (cs_fall) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (state_q == CMD || (state_q == DATA && bit_cnt_q != '0)) frame_err_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_rise) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_sr_d = cmd_word[DATA_WIDTH-2:0];
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            dir_wr_d  = cmd_word[DATA_WIDTH-1];
                            ptr_d     = cmd_word[ADDR_WIDTH-1:0];
                            state_d   = DATA;
                            if (!cmd_word[DATA_WIDTH-1]) tx_sr_d = rd_reg(cmd_word[ADDR_WIDTH-1:0]);
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        if (dir_wr_q) rx_sr_d = rx_word[DATA_WIDTH-2:0];
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            ptr_d     = ptr_q + 1'b1;
                            if (dir_wr_q) begin
                                if (ptr_q != '0) begin
                                    wr_pulse_d = 1'b1;
                                    wr_addr_d  = ptr_q;
                                    wr_data_d  = rx_word;
                                end
                            end else begin
                                tx_sr_d = rd_reg(ptr_q + 1'b1);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else if (sck_fall && !dir_wr_q && bit_cnt_q != '0) begin
                        // The fall right after a word boundary keeps the freshly loaded MSB.
                        tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            dir_wr_q    <= 1'b0;
            ptr_q       <= '0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            cipo_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            dir_wr_q    <= dir_wr_d;
            ptr_q       <= ptr_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            cipo_oe_q   <= cs_s2_q;
        end
    end

    // Register bank commits in the clk after wr_pulse, so a same-clk local read sees the old value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_pulse_q) begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr_addr_q == ADDR_WIDTH'(i)) regs_q[i] <= wr_data_q;
            end
        end
    end

    // Local combinational read port.
    always_comb begin
        bus.loc_data = rd_reg(bus.loc_addr);
    end

    assign cipo_bit      = (state_q == DATA && !dir_wr_q) ? tx_sr_q[DATA_WIDTH-1] : 1'b0;
    assign CIPO          = cipo_oe_q ? cipo_bit : 1'bz;
    assign bus.wr_pulse  = wr_pulse_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_target_regfile.sv
// Directed bench for spi_target_regfile: drives SPI mode-0 frames, scores
// writes and read-back words against queued expectations.
module tb_spi_target_regfile;
    localparam int HALF = 5;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    wire  cipo;

    pullup pu_cipo (cipo);

    spi_target_regfile_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

    spi_target_regfile #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .ID_VALUE(8'hA5)) dut (
        .clk  (clk),
        .rst  (rst_n),
        .bus  (bus.slave),
        .CIPO (cipo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int ferr_seen = 0;
    wr_t exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] model [8];
    logic coll_pending = 1'b0;
    logic [7:0] coll_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write/frame-error monitor: pops expected writes as the DUT strobes them.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n === 1'b1 && bus.wr_pulse === 1'b1) begin
            wr_seen++;
            if (exp_wr_q.size() == 0) begin
                chk("wr_unexpected", 32'(bus.wr_pulse), 32'd0);
            end else begin
                e = exp_wr_q.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.a));
                chk("wr_data", 32'(bus.wr_data), 32'(e.d));
                if (bus.loc_addr == e.a) begin
                    chk("coll_old", 32'(bus.loc_data), 32'(model[e.a]));
                    coll_pending = 1'b1;
                    coll_val = e.d;
                end
                model[e.a] = e.d;
            end
        end else if (coll_pending) begin
            chk("coll_new", 32'(bus.loc_data), 32'(coll_val));
            coll_pending = 1'b0;
        end
        if (bus.frame_err === 1'b1) ferr_seen++;
    end

    task automatic xbit(input logic tx, output logic rx);
        bus.COPI = tx;
        repeat (HALF) @(negedge clk);
        rx = cipo;
        bus.SCK = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.SCK = 1'b0;
    endtask

    task automatic xbyte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) xbit(tx[i], rx[i]);
    endtask

    task automatic cs_on();
        bus.CS = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_off();
        repeat (HALF) @(negedge clk);
        bus.CS = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic rd_word(input string tag);
        logic [7:0] rx;
        logic [7:0] e;
        xbyte(8'h00, rx);
        e = exp_rd_q.pop_front();
        chk(tag, 32'(rx), 32'(e));
    endtask

    task automatic loc_chk(input logic [2:0] a, input logic [7:0] e, input string tag);
        bus.loc_addr = a;
        @(negedge clk);
        chk(tag, 32'(bus.loc_data), 32'(e));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        model[0] = 8'hA5;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        logic b;
        int wr0, fe0;
        bus.SCK = 1'b0; bus.CS = 1'b0; bus.COPI = 1'b0; bus.loc_addr = 3'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (10) @(negedge clk);
        chk("rst_wr_pulse", 32'(bus.wr_pulse), 32'd0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
        chk("rst_cipo_z", 32'(cipo), 32'd1);
        loc_chk(3'd0, 8'hA5, "rst_reg0");
        loc_chk(3'd3, 8'h00, "rst_reg3");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // ID read
        cs_on();
        chk("idle_cipo_0", 32'(cipo), 32'd0);
        xbyte(8'h00, rx);
        exp_rd_q.push_back(8'hA5);
        rd_word("rd_id");
        cs_off();
        chk("cipo_z_after_id", 32'(cipo), 32'd1);
        chk("id_no_wr", 32'(wr_seen), 32'd0);

        // Single write with local read on the same address, then read back
        bus.loc_addr = 3'd3;
        cs_on();
        xbyte(8'h83, rx);
        exp_wr_q.push_back('{a: 3'd3, d: 8'h3C});
        xbyte(8'h3C, rx);
        cs_off();
        chk("single_wr_cnt", 32'(wr_seen), 32'd1);
        loc_chk(3'd3, 8'h3C, "loc_reg3");
        cs_on();
        xbyte(8'h03, rx);
        exp_rd_q.push_back(8'h3C);
        rd_word("rd_reg3");
        cs_off();

        // Wrapping burst write; address 0 dropped
        wr0 = wr_seen;
        cs_on();
        xbyte(8'h86, rx);
        exp_wr_q.push_back('{a: 3'd6, d: 8'h11});
        xbyte(8'h11, rx);
        exp_wr_q.push_back('{a: 3'd7, d: 8'h22});
        xbyte(8'h22, rx);
        xbyte(8'h33, rx);
        cs_off();
        chk("burst_wr_cnt", 32'(wr_seen - wr0), 32'd2);
        loc_chk(3'd6, 8'h11, "loc_reg6");
        loc_chk(3'd7, 8'h22, "loc_reg7");
        loc_chk(3'd0, 8'hA5, "loc_reg0_kept");
        cs_on();
        xbyte(8'h06, rx);
        exp_rd_q.push_back(8'h11);
        rd_word("burst_rd6");
        exp_rd_q.push_back(8'h22);
        rd_word("burst_rd7");
        exp_rd_q.push_back(8'hA5);
        rd_word("burst_rd0_wrap");
        cs_off();

        // Abort mid-word
        wr0 = wr_seen; fe0 = ferr_seen;
        cs_on();
        xbyte(8'h85, rx);
        for (int i = 0; i < 4; i++) xbit(1'b1, b);
        cs_off();
        chk("abort_ferr", 32'(ferr_seen - fe0), 32'd1);
        chk("abort_no_wr", 32'(wr_seen - wr0), 32'd0);
        loc_chk(3'd5, 8'h00, "abort_reg5");
        cs_on();
        xbyte(8'h85, rx);
        exp_wr_q.push_back('{a: 3'd5, d: 8'h5A});
        xbyte(8'h5A, rx);
        cs_off();
        loc_chk(3'd5, 8'h5A, "after_abort_reg5");
        chk("after_abort_ferr", 32'(ferr_seen - fe0), 32'd1);

        // CS pulse with no SCK at all is a short command
        fe0 = ferr_seen;
        cs_on();
        cs_off();
        chk("empty_cmd_ferr", 32'(ferr_seen - fe0), 32'd1);

        // Reset in the middle of a write data word
        wr0 = wr_seen; fe0 = ferr_seen;
        cs_on();
        xbyte(8'h84, rx);
        for (int i = 0; i < 4; i++) xbit(1'b1, b);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) xbit(1'b1, b);
        chk("rstmid_cipo_0", 32'(cipo), 32'd0);
        cs_off();
        chk("rstmid_no_wr", 32'(wr_seen - wr0), 32'd0);
        chk("rstmid_no_ferr", 32'(ferr_seen - fe0), 32'd0);
        for (int i = 0; i < 8; i++) loc_chk(3'(i), (i == 0) ? 8'hA5 : 8'h00, "rstmid_reg");
        cs_on();
        xbyte(8'h81, rx);
        exp_wr_q.push_back('{a: 3'd1, d: 8'h77});
        xbyte(8'h77, rx);
        cs_off();
        loc_chk(3'd1, 8'h77, "rstmid_then_wr");
        cs_on();
        xbyte(8'h00, rx);
        exp_rd_q.push_back(8'hA5);
        rd_word("rstmid_then_rd");
        cs_off();

        // Deselected activity
        wr0 = wr_seen; fe0 = ferr_seen;
        xbyte(8'h87, rx);
        chk("desel_cipo_z0", 32'(rx), 32'hFF);
        xbyte($urandom_range(0, 255), rx);
        chk("desel_cipo_z1", 32'(rx), 32'hFF);
        chk("desel_no_wr", 32'(wr_seen - wr0), 32'd0);
        chk("desel_no_ferr", 32'(ferr_seen - fe0), 32'd0);
        loc_chk(3'd7, 8'h00, "desel_reg7");

        repeat (4) @(negedge clk);
        chk("exp_wr_drained", 32'(exp_wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
